// File: rtl/regfile_access_ctrl_if.sv
// regfile_access_ctrl_if: one requester's access port into the register-file
// access controller. The requester drives the master side (request, write
// enable, addresses, write data); the controller drives the slave side
// (grant, read-valid pulse, registered read data).
interface regfile_access_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rv1;
  logic [DW-1:0] rv2;

  modport master (
    output req, we, rs1, rs2, rd, wdata,
    input  gnt, rvalid, rv1, rv2
  );

  modport slave (
    input  req, we, rs1, rs2, rd, wdata,
    output gnt, rvalid, rv1, rv2
  );

endinterface

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: shares a 2-read/1-write register file between two
// requesters (A = core datapath, B = debug/host port). One access (two reads
// plus an optional write) is granted per cycle under round-robin arbitration;
// read data is captured at the grant edge and returned one cycle later with a
// single-cycle rvalid pulse. Writes to register 0 are suppressed.
//
// Build option: define REGFILE_ACCESS_CTRL_INIT_EN to add a post-reset sweep
// that writes INIT_VAL to every register before the first grant (busy is high
// during the sweep). Without it, the controller arbitrates straight out of
// reset and busy is tied low.
module regfile_access_ctrl #(
  parameter int            NREG     = 32,
  parameter int            AW       = 5,
  parameter int            DW       = 32,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  regfile_access_ctrl_if.slave a,
  regfile_access_ctrl_if.slave b,
  output logic [AW-1:0] rf_rs1,
  output logic [AW-1:0] rf_rs2,
  output logic [AW-1:0] rf_rd,
  output logic [DW-1:0] rf_indata,
  output logic          rf_we,
  input  logic [DW-1:0] rf_rv1,
  input  logic [DW-1:0] rf_rv2,
  output logic          busy
);

`ifdef REGFILE_ACCESS_CTRL_INIT_EN
  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  typedef enum logic {ST_INIT, ST_ARB} state_t;

  state_t        state;
  logic [AW-1:0] init_cnt;
  logic          in_init;

  assign in_init = (state == ST_INIT);
  assign busy    = in_init;
`else
  logic in_init;

  assign in_init = 1'b0;
  assign busy    = 1'b0;
`endif

  // Round-robin pointer: set when B won the most recent grant.
  logic last_b;
  logic pick_a;
  logic pick_b;

  // Last values presented on the regfile pins, so idle cycles park the bus.
  logic [AW-1:0] hold_rs1;
  logic [AW-1:0] hold_rs2;
  logic [AW-1:0] hold_rd;
  logic [DW-1:0] hold_indata;

  // Winner selection: a lone requester wins; on a tie the non-last winner wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    pick_a = 1'b0;
    pick_b = 1'b0;
    if (!rst && !in_init) begin
      if (a.req && (!b.req || last_b)) begin
        pick_a = 1'b1;
      end else if (b.req) begin
        pick_b = 1'b1;
      end
    end
  end

  assign a.gnt = pick_a;
  assign b.gnt = pick_b;

  // Regfile pin mux: sweep write, winner's fields, or parked idle bus.
  always_comb begin
    rf_rs1    = hold_rs1;
    rf_rs2    = hold_rs2;
    rf_rd     = hold_rd;
    rf_indata = hold_indata;
    rf_we     = 1'b0;
`ifdef REGFILE_ACCESS_CTRL_INIT_EN
    if (in_init) begin
      rf_rd     = init_cnt;
      rf_indata = INIT_VAL;
      rf_we     = !rst;
    end
`endif
    if (pick_a) begin
      rf_rs1    = a.rs1;
      rf_rs2    = a.rs2;
      rf_rd     = a.rd;
      rf_indata = a.wdata;
      rf_we     = a.we && (a.rd != '0);
    end else if (pick_b) begin
      rf_rs1    = b.rs1;
      rf_rs2    = b.rs2;
      rf_rd     = b.rd;
      rf_indata = b.wdata;
      rf_we     = b.we && (b.rd != '0);
    end
  end

  // Sweep FSM, arbitration pointer, bus parking and read-data return.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
`ifdef REGFILE_ACCESS_CTRL_INIT_EN
      state    <= ST_INIT;
      init_cnt <= '0;
`endif
      last_b      <= 1'b1;
      hold_rs1    <= '0;
      hold_rs2    <= '0;
      hold_rd     <= '0;
      hold_indata <= INIT_VAL;
      a.rvalid    <= 1'b0;
      b.rvalid    <= 1'b0;
      a.rv1       <= '0;
      a.rv2       <= '0;
      b.rv1       <= '0;
      b.rv2       <= '0;
    end else begin
`ifdef REGFILE_ACCESS_CTRL_INIT_EN
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST_REG) begin
          state <= ST_ARB;
        end
      end
`endif
      hold_rs1    <= rf_rs1;
      hold_rs2    <= rf_rs2;
      hold_rd     <= rf_rd;
      hold_indata <= rf_indata;
      a.rvalid    <= pick_a;
      b.rvalid    <= pick_b;
      // Asynchronous regfile read seen before the edge is the pre-write value.
      if (pick_a) begin
        a.rv1  <= rf_rv1;
        a.rv2  <= rf_rv2;
        last_b <= 1'b0;
      end
      if (pick_b) begin
        b.rv1  <= rf_rv1;
        b.rv2  <= rf_rv2;
        last_b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: self-checking bench for regfile_access_ctrl.
// Provides a behavioural 32x32 regfile with asynchronous read, a shadow model
// of its contents, a round-robin reference arbiter, and a scoreboard queue of
// expected read data per requester.
module tb_regfile_access_ctrl;

  localparam int            NREG     = 32;
  localparam int            AW       = 5;
  localparam int            DW       = 32;
  localparam logic [DW-1:0] INIT_VAL = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_access_ctrl_if #(.AW(AW), .DW(DW)) a_if ();
  regfile_access_ctrl_if #(.AW(AW), .DW(DW)) b_if ();

  logic [AW-1:0] rf_rs1;
  logic [AW-1:0] rf_rs2;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_indata;
  logic          rf_we;
  logic [DW-1:0] rf_rv1;
  logic [DW-1:0] rf_rv2;
  logic          busy;

  regfile_access_ctrl #(
    .NREG(NREG), .AW(AW), .DW(DW), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk(clk), .rst(rst), .a(a_if), .b(b_if),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd), .rf_indata(rf_indata),
    .rf_we(rf_we), .rf_rv1(rf_rv1), .rf_rv2(rf_rv2), .busy(busy)
  );

  // Behavioural regfile: asynchronous read, write on the rising edge.
  logic [DW-1:0] mem [NREG];
  assign rf_rv1 = mem[rf_rs1];
  assign rf_rv2 = mem[rf_rs2];
  always @(posedge clk) if (rf_we) mem[rf_rd] <= rf_indata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit                mon_en = 1'b0;
  logic [DW-1:0]     shadow [NREG];
  logic [2*DW-1:0]   qa[$];
  logic [2*DW-1:0]   qb[$];
  logic [2*DW-1:0]   last_a_rv;
  logic [2*DW-1:0]   last_b_rv;
  bit                exp_rv_a;
  bit                exp_rv_b;
  bit                last_b_m;

  task automatic model_reset(input logic [DW-1:0] val);
    for (int i = 0; i < NREG; i++) shadow[i] = val;
    qa.delete();
    qb.delete();
    last_a_rv = '0;
    last_b_rv = '0;
    exp_rv_a  = 1'b0;
    exp_rv_b  = 1'b0;
    last_b_m  = 1'b1;
  endtask

  task automatic model_grant(input logic we, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic [DW-1:0] wdata,
                             output logic [2*DW-1:0] rv);
    rv = {shadow[rs1], shadow[rs2]};
    check("rf_we", rf_we, we && (rd != '0));
    if (we && (rd != '0)) begin
      check("rf_rd", rf_rd, rd);
      check("rf_indata", rf_indata, wdata);
      shadow[rd] = wdata;
    end
  endtask

  // Monitor: checks read return against the scoreboard and grants against the model.
  always @(negedge clk) begin : monitor
    logic [2*DW-1:0] e;
    logic            m_a;
    logic            m_b;
    if (mon_en) begin
      check("a_rvalid", a_if.rvalid, exp_rv_a);
      check("b_rvalid", b_if.rvalid, exp_rv_b);
      if (exp_rv_a && qa.size() != 0) begin
        e = qa.pop_front();
        check("a_rv", {a_if.rv1, a_if.rv2}, e);
        last_a_rv = e;
      end else begin
        check("a_rv_hold", {a_if.rv1, a_if.rv2}, last_a_rv);
      end
      if (exp_rv_b && qb.size() != 0) begin
        e = qb.pop_front();
        check("b_rv", {b_if.rv1, b_if.rv2}, e);
        last_b_rv = e;
      end else begin
        check("b_rv_hold", {b_if.rv1, b_if.rv2}, last_b_rv);
      end
      m_a = a_if.req && (!b_if.req || last_b_m);
      m_b = b_if.req && !m_a;
      check("a_gnt", a_if.gnt, m_a);
      check("b_gnt", b_if.gnt, m_b);
      exp_rv_a = m_a;
      exp_rv_b = m_b;
      if (m_a) begin
        model_grant(a_if.we, a_if.rs1, a_if.rs2, a_if.rd, a_if.wdata, e);
        qa.push_back(e);
        last_b_m = 1'b0;
      end else if (m_b) begin
        model_grant(b_if.we, b_if.rs1, b_if.rs2, b_if.rd, b_if.wdata, e);
        qb.push_back(e);
        last_b_m = 1'b1;
      end else begin
        check("idle_rf_we", rf_we, 1'b0);
      end
    end
  end

  task automatic drive(input bit is_b, input logic req, input logic we,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic [DW-1:0] wdata);
    if (is_b) begin
      b_if.req = req; b_if.we = we; b_if.rs1 = rs1; b_if.rs2 = rs2; b_if.rd = rd; b_if.wdata = wdata;
    end else begin
      a_if.req = req; a_if.we = we; a_if.rs1 = rs1; a_if.rs2 = rs2; a_if.rd = rd; a_if.wdata = wdata;
    end
  endtask

  // Called at the start of a cycle; returns at the start of the rvalid cycle.
  task automatic access(input bit is_b, input logic we, input logic [AW-1:0] rs1,
                        input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                        input logic [DW-1:0] wdata, output logic we_seen);
    bit got;
    got     = 1'b0;
    we_seen = 1'b0;
    drive(is_b, 1'b1, we, rs1, rs2, rd, wdata);
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk); #1;
      got     = is_b ? b_if.gnt : a_if.gnt;
      we_seen = rf_we;
    end
    check(is_b ? "b_gnt_wait" : "a_gnt_wait", got, 1'b1);
    @(posedge clk); #1;
    if (is_b) b_if.req = 1'b0; else a_if.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic we_seen;
    bit   a_pend;
    bit   b_pend;

`ifdef REGFILE_ACCESS_CTRL_INIT_EN
    for (int i = 0; i < NREG; i++) mem[i] = 32'hA5A5_0000 | i;
`else
    for (int i = 0; i < NREG; i++) mem[i] = '0;
`endif

    // Reset: requests are ignored while rst is high.
    drive(1'b0, 1'b1, 1'b0, 5'd3, 5'd31, 5'd0, '0);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_a_gnt", a_if.gnt, 1'b0);
    check("rst_b_gnt", b_if.gnt, 1'b0);
    check("rst_a_rvalid", a_if.rvalid, 1'b0);
    check("rst_b_rvalid", b_if.rvalid, 1'b0);
    check("rst_a_rv", {a_if.rv1, a_if.rv2}, '0);
    check("rst_b_rv", {b_if.rv1, b_if.rv2}, '0);
`ifdef REGFILE_ACCESS_CTRL_INIT_EN
    check("rst_busy", busy, 1'b1);

    // Init sweep with A requesting throughout.
    @(posedge clk); #1;
    rst = 1'b0;
    b_if.req = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk); #1;
      check("sweep_busy", busy, 1'b1);
      check("sweep_we", rf_we, 1'b1);
      check("sweep_rd", rf_rd, i);
      check("sweep_a_gnt", a_if.gnt, 1'b0);
      if (i == 0) begin
        check("rel_a_rvalid", a_if.rvalid, 1'b0);
        check("rel_a_rv", {a_if.rv1, a_if.rv2}, '0);
      end
    end
    model_reset(INIT_VAL);
    mon_en = 1'b1;
    @(negedge clk); #1;
    check("post_sweep_a_gnt", a_if.gnt, 1'b1);
    check("post_sweep_busy", busy, 1'b0);
    @(posedge clk); #1;
    a_if.req = 1'b0;
`else
    check("rst_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    model_reset('0);
    mon_en = 1'b1;
    @(negedge clk); #1;
    check("rel_a_rvalid", a_if.rvalid, 1'b0);
    check("rel_a_rv", {a_if.rv1, a_if.rv2}, '0);
    @(posedge clk); #1;
`endif

    // Single write then read.
    access(1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 32'hDEADBEEF, we_seen);
    access(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, we_seen);
    check("wr_rd_rvalid", a_if.rvalid, 1'b1);
    check("wr_rd_rv1", a_if.rv1, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("wr_rd_pulse_end", a_if.rvalid, 1'b0);

    // Read-during-write returns the old value.
    access(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11, we_seen);
    access(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h22, we_seen);
    check("rdw_old", a_if.rv1, 32'h11);
    access(1'b0, 1'b0, 5'd7, 5'd5, 5'd0, 32'h0, we_seen);
    check("rdw_new", a_if.rv1, 32'h22);

    // x0 protection.
    access(1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 32'hFFFFFFFF, we_seen);
    check("x0_rf_we", we_seen, 1'b0);
    access(1'b1, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0, we_seen);
    check("x0_read", b_if.rv1, 32'h0);

    // Contention: B won last, so A leads and grants alternate.
    drive(1'b0, 1'b1, 1'b1, 5'd9, 5'd5, 5'd9, 32'hAAAA0009);
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd5, 5'd0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check("cont_a_gnt", a_if.gnt, (i % 2) == 0);
      check("cont_b_gnt", b_if.gnt, (i % 2) == 1);
      @(posedge clk); #1;
    end
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

`ifdef REGFILE_ACCESS_CTRL_INIT_EN
    // Reset at counter 12 restarts the sweep from register 0.
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      check("sweep1_rd", rf_rd, i);
      @(posedge clk); #1;
    end
    check("sweep1_rd12", rf_rd, 5'd12);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      @(negedge clk); #1;
      check("sweep2_busy", busy, 1'b1);
      check("sweep2_we", rf_we, 1'b1);
      check("sweep2_rd", rf_rd, i);
      @(posedge clk); #1;
    end
    check("sweep2_done", busy, 1'b0);
    model_reset(INIT_VAL);
    mon_en = 1'b1;
    access(1'b0, 1'b0, 5'd5, 5'd9, 5'd0, 32'h0, we_seen);
    check("sweep2_cleared", a_if.rv1, INIT_VAL);
`endif

    // Random traffic with abandons; fields held stable while pending.
    a_pend = 1'b0;
    b_pend = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!a_pend)
        drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
              AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom()));
      else if ($urandom_range(0, 3) == 0)
        a_if.req = 1'b0;
      if (!b_pend)
        drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
              AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)), DW'($urandom()));
      else if ($urandom_range(0, 3) == 0)
        b_if.req = 1'b0;
      @(negedge clk); #1;
      a_pend = a_if.req && !a_if.gnt;
      b_pend = b_if.req && !b_if.gnt;
      @(posedge clk); #1;
    end
    a_if.req = 1'b0;
    b_if.req = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
